// File: rtl/icache_direct.sv
// Direct-mapped instruction cache: 1-cycle hits, 8-byte line fill on miss.
// Ports: fetch side if_req/if_pc -> if_valid/if_instr; memory side mem_req/mem_a <- mem_d/mem_done.
module icache_direct #(
  parameter int INDEX_BITS = 4
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        clear_signal,
  input  logic        if_req,
  input  logic [31:0] if_pc,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic        mem_req,
  output logic [31:0] mem_a,
  input  logic [63:0] mem_d,
  input  logic        mem_done
);

  localparam int LINES = 1 << INDEX_BITS;
  localparam int TAG_W = 29 - INDEX_BITS;

  localparam logic S_IDLE = 1'b0;
  localparam logic S_MISS = 1'b1;

  logic              state_q, state_d;
  logic [LINES-1:0]  valid_q, valid_d;
  logic              if_valid_q, if_valid_d;
  logic [31:0]       if_instr_q, if_instr_d;
  logic              mem_req_q, mem_req_d;
  logic [31:0]       mem_a_q, mem_a_d;
  logic [31:0]       pc_q, pc_d;
  logic              fill_en;

  logic [TAG_W-1:0]  tag_q  [LINES];
  logic [63:0]       data_q [LINES];

  logic [INDEX_BITS-1:0] idx;
  logic [INDEX_BITS-1:0] fill_idx;
  logic [TAG_W-1:0]      req_tag;
  logic                  hit;
  logic [63:0]           line;
  logic                  unused_ok;

  assign idx       = if_pc[2+INDEX_BITS:3];
  assign req_tag   = if_pc[31:3+INDEX_BITS];
  assign fill_idx  = pc_q[2+INDEX_BITS:3];
  assign line      = data_q[idx];
  assign hit       = valid_q[idx] && (tag_q[idx] == req_tag);
  assign unused_ok = ^{if_pc[1:0], pc_q[1:0]};

  always_comb begin
    state_d    = state_q;
    valid_d    = valid_q;
    if_valid_d = if_valid_q;
    if_instr_d = if_instr_q;
    mem_req_d  = mem_req_q;
    mem_a_d    = mem_a_q;
    pc_d       = pc_q;
    fill_en    = 1'b0;
    if (rdy_in) begin
      case (state_q)
        S_IDLE: begin
          if_valid_d = 1'b0;
          if (if_req && !clear_signal) begin
            if (hit) begin
              if_valid_d = 1'b1;
              if_instr_d = if_pc[2] ? line[63:32] : line[31:0];
            end else begin
              state_d   = S_MISS;
              mem_req_d = 1'b1;
              mem_a_d   = {if_pc[31:3], 3'b000};
              pc_d      = if_pc;
            end
          end
        end
        default: begin
          if_valid_d = 1'b0;
          if (mem_done) begin
            // Line is filled even when the response is flushed.
            fill_en           = 1'b1;
            valid_d[fill_idx] = 1'b1;
            mem_req_d         = 1'b0;
            state_d           = S_IDLE;
            if (!clear_signal) begin
              if_valid_d = 1'b1;
              if_instr_d = pc_q[2] ? mem_d[63:32] : mem_d[31:0];
            end
          end else if (clear_signal) begin
            mem_req_d = 1'b0;
            state_d   = S_IDLE;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q    <= S_IDLE;
      valid_q    <= '0;
      if_valid_q <= 1'b0;
      if_instr_q <= '0;
      mem_req_q  <= 1'b0;
      mem_a_q    <= '0;
      pc_q       <= '0;
    end else begin
      state_q    <= state_d;
      valid_q    <= valid_d;
      if_valid_q <= if_valid_d;
      if_instr_q <= if_instr_d;
      mem_req_q  <= mem_req_d;
      mem_a_q    <= mem_a_d;
      pc_q       <= pc_d;
    end
  end

  always_ff @(posedge clk_in) begin
    if (fill_en) begin
      tag_q[fill_idx]  <= pc_q[31:3+INDEX_BITS];
      data_q[fill_idx] <= mem_d;
    end
  end

  assign if_valid = if_valid_q;
  assign if_instr = if_instr_q;
  assign mem_req  = mem_req_q;
  assign mem_a    = mem_a_q;

endmodule
